// File: rtl/aes_sched.sv
// aes_sched: round-robin scheduler that shares one AES core between two
// requesters. It runs one transaction at a time through IDLE -> ISSUE -> WAIT -> RESP.
// Optional feature macro: AES_SCHED_TIMEOUT_EN. When it is defined, a WAIT
// that lasts TIMEOUT_CYCLES cycles ends with an error response.
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both 1. A producer holds valid and its payload stable until it
// sees ready. On the request side, ready is a combinational grant from IDLE.
// rsp_* stay stable while rsp_valid=1 and rsp_ready=0.
module aes_sched #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_state,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_state,
  input  logic [127:0] req1_key,
  output logic         core_start,
  output logic [127:0] core_state,
  output logic [127:0] core_key,
  input  logic         core_done,
  input  logic [127:0] core_out,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   last_served;
  logic   gnt_any;
  logic   gnt_id;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("aes_sched: TIMEOUT_CYCLES must be at least 1");
  end

  assign dbg_state = state;

`ifdef AES_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
  logic          to_fire;

  // Count WAIT cycles; the counter restarts in ISSUE, just before WAIT begins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state == S_ISSUE) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

  // Round-robin choice: on a tie, the requester not served last wins.
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    gnt_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_id = ~last_served;
    end else begin
      gnt_id = req1_valid;
    end
  end

  // Next-state logic and per-state strobes.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    core_start = 1'b0;
    rsp_valid  = 1'b0;
`ifdef AES_SCHED_TIMEOUT_EN
    to_fire    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (gnt_any) begin
          req0_ready = ~gnt_id;
          req1_ready = gnt_id;
          state_nxt  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        core_start = 1'b1;
        state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          state_nxt = S_RESP;
`ifdef AES_SCHED_TIMEOUT_EN
        end else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          to_fire   = 1'b1;
          state_nxt = S_RESP;
`endif
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath: latch the granted pair, capture the result, advance the pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_state  <= '0;
      core_key    <= '0;
      rsp_id      <= 1'b0;
      rsp_data    <= '0;
      last_served <= 1'b1;
`ifdef AES_SCHED_TIMEOUT_EN
      rsp_err     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_any) begin
            core_state <= gnt_id ? req1_state : req0_state;
            core_key   <= gnt_id ? req1_key : req0_key;
            rsp_id     <= gnt_id;
          end
        end
        S_WAIT: begin
          if (core_done) begin
            rsp_data <= core_out;
`ifdef AES_SCHED_TIMEOUT_EN
            rsp_err  <= 1'b0;
          end else if (to_fire) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
`endif
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            last_served <= rsp_id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sched.sv
// Directed testbench for aes_sched: single AES vector, response stall,
// round-robin ordering, reset mid-transaction, and the timeout (or endless
// WAIT) behaviour that depends on AES_SCHED_TIMEOUT_EN.
module tb_aes_sched;

  localparam int TO = 8;
  localparam int W  = 130;
  localparam logic [127:0] AES_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] AES_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] AES_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk;
  logic         rst;
  logic         req0_valid, req0_ready;
  logic [127:0] req0_state, req0_key;
  logic         req1_valid, req1_ready;
  logic [127:0] req1_state, req1_key;
  logic         core_start;
  logic [127:0] core_state, core_key;
  logic         core_done;
  logic [127:0] core_out;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [127:0] rsp_data;
  logic [1:0]   dbg_state;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [0:0]   gnt_log[$];
  logic         core_en;
  int           core_lat;

  aes_sched #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_state(req0_state), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_state(req1_state), .req1_key(req1_key),
    .core_start(core_start), .core_state(core_state), .core_key(core_key),
    .core_done(core_done), .core_out(core_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Stand-in AES core: the known vector maps to its ciphertext, anything else to state^key.
  function automatic logic [127:0] core_fn(input logic [127:0] s, input logic [127:0] k);
    return (s == AES_PT && k == AES_KEY) ? AES_CT : (s ^ k);
  endfunction

  initial begin
    logic [127:0] r;
    core_done = 1'b0;
    core_out  = '0;
    forever begin
      @(negedge clk);
      if (core_start === 1'b1 && core_en) begin
        r = core_fn(core_state, core_key);
        repeat (core_lat) @(posedge clk);
        #1 core_done = 1'b1;
        core_out = r;
        @(posedge clk);
        #1 core_done = 1'b0;
      end
    end
  end

  // Scoreboard: grants push {err,id,data}; response handshakes pop and compare.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst) begin
      chk("ready_excl", 128'(req0_ready & req1_ready), 128'(0));
      if (dbg_state != 2'd0) chk("ready_idle_only", 128'({req0_ready, req1_ready}), 128'(0));
      if (req0_ready) begin
        gnt_log.push_back(1'b0);
        exp_q.push_back({~core_en, 1'b0, core_en ? core_fn(req0_state, req0_key) : 128'(0)});
      end
      if (req1_ready) begin
        gnt_log.push_back(1'b1);
        exp_q.push_back({~core_en, 1'b1, core_en ? core_fn(req1_state, req1_key) : 128'(0)});
      end
      if (rsp_valid && rsp_ready) begin
        chk("sb_pending", 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_id", 128'(rsp_id), 128'(e[128]));
          chk("sb_data", rsp_data, e[127:0]);
          chk("sb_err", 128'(rsp_err), 128'(e[129]));
        end
      end
    end
  end

  // Consumer handshake driver: call #1 after a rising edge.
  task automatic do_hs(input string tag);
    int n;
    n = 0;
    rsp_ready = 1'b1;
    @(negedge clk);
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 128'(rsp_valid), 128'(1));
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  // Directed sequence.
  initial begin
    int cyc, n, k0, k1;
    logic g0, g1;
    rst = 1'b0; rsp_ready = 1'b0; core_en = 1'b1; core_lat = 10;
    req0_valid = 1'b0; req0_state = '0; req0_key = '0;
    req1_valid = 1'b0; req1_state = '0; req1_key = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 128'(dbg_state), 128'(0));
    chk("rst_start", 128'(core_start), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_rsp_err", 128'(rsp_err), 128'(0));
    chk("rst_rsp_id", 128'(rsp_id), 128'(0));
    chk("rst_readies", 128'({req0_ready, req1_ready}), 128'(0));
    chk("rst_core_state", core_state, 128'(0));
    chk("rst_core_key", core_key, 128'(0));
    chk("rst_rsp_data", rsp_data, 128'(0));
    @(posedge clk); #1 rst = 1'b1;

    // Single AES request with latency check.
    @(posedge clk); #1 req0_valid = 1'b1; req0_state = AES_PT; req0_key = AES_KEY;
    @(negedge clk);
    chk("t1_req0_ready", 128'(req0_ready), 128'(1));
    chk("t1_req1_ready", 128'(req1_ready), 128'(0));
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    chk("t1_core_start", 128'(core_start), 128'(1));
    chk("t1_core_state", core_state, AES_PT);
    chk("t1_core_key", core_key, AES_KEY);
    @(negedge clk);
    cyc = 2;
    chk("t1_start_once", 128'(core_start), 128'(0));
    while (!rsp_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk("t1_latency", 128'(cyc), 128'(12));
    chk("t1_core_key_hold", core_key, AES_KEY);
    chk("t1_rsp_id", 128'(rsp_id), 128'(0));
    chk("t1_rsp_data", rsp_data, AES_CT);
    chk("t1_rsp_err", 128'(rsp_err), 128'(0));
    @(posedge clk); #1;
    do_hs("t1_hs");

    // Response stall with req1 waiting.
    req0_valid = 1'b1; req0_state = 128'h00112233445566778899aabbccddeeff;
    req0_key = 128'h000102030405060708090a0b0c0d0e0f;
    @(negedge clk);
    chk("t2_req0_ready", 128'(req0_ready), 128'(1));
    @(posedge clk); #1 req0_valid = 1'b0;
    req1_valid = 1'b1; req1_state = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    req1_key = 128'hffffffff_00000000_ffffffff_00000000;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("t2_stall_valid", 128'(rsp_valid), 128'(1));
      chk("t2_stall_id", 128'(rsp_id), 128'(0));
      chk("t2_stall_data", rsp_data, 128'h00102030405060708090a0b0c0d0e0f0);
      chk("t2_stall_err", 128'(rsp_err), 128'(0));
      chk("t2_req1_blocked", 128'(req1_ready), 128'(0));
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("t2_hs_req1_blocked", 128'(req1_ready), 128'(0));
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("t2_req1_granted", 128'(req1_ready), 128'(1));
    @(posedge clk); #1 req1_valid = 1'b0;
    do_hs("t2_hs_req1");

    // Round-robin with both requesters continuously valid.
    gnt_log.delete();
    rsp_ready = 1'b1;
    k0 = 0; k1 = 0; n = 0;
    req0_valid = 1'b1; req0_state = {4{32'h0a0b0c00}}; req0_key = {4{32'h11110000}};
    req1_valid = 1'b1; req1_state = {4{32'h0d0e0f00}}; req1_key = {4{32'h22220000}};
    while (gnt_log.size() < 4 && n < 400) begin
      @(negedge clk);
      g0 = req0_ready; g1 = req1_ready;
      @(posedge clk); #1;
      n++;
      if (g0) begin
        k0++;
        if (k0 < 2) req0_state = {4{32'h0a0b0c00 + 32'(k0)}};
        else req0_valid = 1'b0;
      end
      if (g1) begin
        k1++;
        if (k1 < 2) req1_state = {4{32'h0d0e0f00 + 32'(k1)}};
        else req1_valid = 1'b0;
      end
    end
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1 rsp_ready = 1'b0;
    chk("t3_grant_count", 128'(gnt_log.size()), 128'(4));
    if (gnt_log.size() == 4) begin
      chk("t3_order0", 128'(gnt_log[0]), 128'(0));
      chk("t3_order1", 128'(gnt_log[1]), 128'(1));
      chk("t3_order2", 128'(gnt_log[2]), 128'(0));
      chk("t3_order3", 128'(gnt_log[3]), 128'(1));
    end

    // Reset during WAIT, late core_done ignored.
    @(posedge clk); #1 req1_valid = 1'b1; req1_state = 128'h55; req1_key = 128'haa;
    @(negedge clk);
    chk("t4_req1_ready", 128'(req1_ready), 128'(1));
    @(posedge clk); #1 req1_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t4_in_wait", 128'(dbg_state), 128'(2));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t4_rst_state", 128'(dbg_state), 128'(0));
    chk("t4_rst_id", 128'(rsp_id), 128'(0));
    chk("t4_rst_core_state", core_state, 128'(0));
    chk("t4_rst_core_key", core_key, 128'(0));
    chk("t4_rst_rsp_valid", 128'(rsp_valid), 128'(0));
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("t4_no_rsp", 128'(rsp_valid), 128'(0));
    end
    chk("t4_idle_after", 128'(dbg_state), 128'(0));
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_state = 128'h1234; req0_key = 128'h4321;
    req1_valid = 1'b1; req1_state = 128'h5678; req1_key = 128'h8765;
    @(negedge clk);
    chk("t4_tie_req0", 128'(req0_ready), 128'(1));
    chk("t4_tie_req1", 128'(req1_ready), 128'(0));
    @(posedge clk); #1 req0_valid = 1'b0;
    do_hs("t4_hs0");
    n = 0;
    @(negedge clk);
    while (!req1_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t4_req1_served", 128'(req1_ready), 128'(1));
    @(posedge clk); #1 req1_valid = 1'b0;
    do_hs("t4_hs1");

`ifdef AES_SCHED_TIMEOUT_EN
    // Core never answers: timeout error response.
    core_en = 1'b0;
    @(posedge clk); #1 req0_valid = 1'b1; req0_state = 128'h77; req0_key = 128'h88;
    @(negedge clk);
    cyc = 0;
    chk("t5_req0_ready", 128'(req0_ready), 128'(1));
    @(posedge clk); #1 req0_valid = 1'b0;
    while (!rsp_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk("t5_timeout_cycle", 128'(cyc), 128'(2 + TO));
    chk("t5_err", 128'(rsp_err), 128'(1));
    chk("t5_data", rsp_data, 128'(0));
    chk("t5_id", 128'(rsp_id), 128'(0));
    @(posedge clk); #1;
    do_hs("t5_hs");
    core_en = 1'b1;
`else
    // Core never answers: WAIT persists, reset recovers.
    core_en = 1'b0;
    @(posedge clk); #1 req0_valid = 1'b1; req0_state = 128'h77; req0_key = 128'h88;
    @(negedge clk);
    chk("t5_req0_ready", 128'(req0_ready), 128'(1));
    @(posedge clk); #1 req0_valid = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("t5_still_wait", 128'(dbg_state), 128'(2));
    chk("t5_no_rsp", 128'(rsp_valid), 128'(0));
    chk("t5_err_const", 128'(rsp_err), 128'(0));
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b1;
    core_en = 1'b1;
`endif

    repeat (3) @(posedge clk);
    chk("sb_drained", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aes_sched.md
AES_SCHED -- requirements
Module: aes_sched

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum number of WAIT cycles before the core is declared hung (used only under AES_SCHED_TIMEOUT_EN).
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 reqN_valid  input  1  (N=0,1) requester N presents a plaintext/key pair.
REQ-005 reqN_ready  output  1  (N=0,1) requester N's pair is accepted this cycle.
REQ-006 reqN_state  input  128  (N=0,1) plaintext block.
REQ-007 reqN_key  input  128  (N=0,1) cipher key.
REQ-008 core_start  output  1  one-cycle launch pulse to the shared AES core.
REQ-009 core_state  output  128  plaintext driven to the core.
REQ-010 core_key  output  128  key driven to the core.
REQ-011 core_done  input  1  core result valid, single-cycle pulse.
REQ-012 core_out  input  128  core ciphertext.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  consumer accepts the response.
REQ-015 rsp_id  output  1  index of the requester that owns the response.
REQ-016 rsp_data  output  128  ciphertext.
REQ-017 rsp_err  output  1  response is a timeout error.

Function
REQ-018 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP, with one transaction in flight at a time.
REQ-019 IDLE: when any reqN_valid=1, SHALL grant exactly one requester, assert its reqN_ready combinationally in that cycle, register its state/key/id, and go to ISSUE.
REQ-020 Arbitration SHALL be round-robin: when both requesters are valid, the grant goes to the requester not served last; a single valid requester is granted immediately.
REQ-021 The last-served pointer SHALL update only on a rsp_valid&&rsp_ready handshake.
REQ-022 reqN_ready SHALL be 0 in every state other than IDLE, and SHALL never be 1 for both requesters in the same cycle.
REQ-023 ISSUE: SHALL assert core_start=1 for exactly one cycle and go to WAIT.
REQ-024 core_state/core_key SHALL hold the registered values from ISSUE through WAIT.
REQ-025 WAIT: on core_done=1, SHALL capture core_out into rsp_data, set rsp_err=0, and go to RESP.
REQ-026 core_done outside WAIT SHALL be ignored.
REQ-027 RESP: rsp_valid=1, and rsp_id/rsp_data/rsp_err SHALL stay stable until rsp_ready=1; on that handshake the FSM SHALL return to IDLE.
REQ-028 A new request SHALL be granted no earlier than the cycle after the RESP handshake.
REQ-029 Latency SHALL be: grant at cycle 0, core_start at cycle 1, rsp_valid at the cycle after core_done.
REQ-030 A requester SHALL hold reqN_valid and its data until it sees reqN_ready; dropping valid earlier withdraws the request with no side effects.

Reset
REQ-031 While rst=0, the block SHALL force: state IDLE; core_start, rsp_valid, rsp_err, rsp_id and both reqN_ready all 0; core_state, core_key and rsp_data all zero; last-served pointer =1, so requester 0 wins the first tie.
REQ-032 Reset asserted mid-transaction SHALL discard the transaction without issuing any response; a late core_done after reset SHALL be ignored.

Configuration
REQ-033 With AES_SCHED_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-034 With AES_SCHED_TIMEOUT_EN defined, if the counter reaches TIMEOUT_CYCLES without core_done, the FSM SHALL go to RESP with rsp_err=1 and rsp_data=0.
REQ-035 Without AES_SCHED_TIMEOUT_EN, there SHALL be no counter, rsp_err SHALL be constant 0, and WAIT SHALL last indefinitely.

Verification
REQ-036 Single request: req0 state=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c, core model responding after 10 cycles -> rsp_id=0, rsp_data=3925841d02dc09fbdc118597196a0b32, rsp_err=0, rsp_valid at cycle 12.
REQ-037 Both requesters valid continuously for 4 transactions -> grant order 0,1,0,1, with never two ready signals in one cycle.
REQ-038 rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable throughout; req1 held valid gets no ready until the handshake.
REQ-039 rst=0 asserted during WAIT, then core_done pulsed after release -> no rsp_valid; the next request is served normally.
REQ-040 AES_SCHED_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, core never responds -> rsp_valid after 8 WAIT cycles with rsp_err=1 and rsp_data=0.
